// File: rtl/game_flow_ctrl_if.sv
// Bundle of key/collision/score inputs and flow-control outputs of the
// game-flow sequencer. The master side drives the game inputs, the slave
// side (the sequencer) drives the flow-control outputs.
interface game_flow_ctrl_if;
  logic [1:0]  key;
  logic        collide;
  logic        game_tick;
  logic [15:0] score;
  logic        game_rst;
  logic        over;
  logic [15:0] hi;
  logic        bgtype;
  logic [3:0]  bg;
  logic [2:0]  state;

  modport master (
    output key, collide, game_tick, score,
    input  game_rst, over, hi, bgtype, bg, state
  );

  modport slave (
    input  key, collide, game_tick, score,
    output game_rst, over, hi, bgtype, bg, state
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: holds/releases the play field, freezes it on a
// collision, keeps the high score and fades the background between day
// and night as the score advances.
//
// state      | meaning
// -----------+---------------------------------------------------------
// FROZEN     | power-up idle, play field held in reset
// START      | start key pressed, waiting for its release
// RUN        | game running, collisions and day/night evaluated
// OVER_HELD  | game over, key from the last run still held
// OVER_ARMED | game over, key released, next press restarts
// RESTART    | restart key pressed, waiting for its release
module game_flow_ctrl #(
  parameter logic [15:0] PERIOD    = 16'h700,
  parameter logic [15:0] DAY_START = 16'h200,
  parameter int          FADE_DIV  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  game_flow_ctrl_if.slave  bus
);

  localparam int PW = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(FADE_DIV - 1);

  typedef enum logic [2:0] {
    FROZEN     = 3'd0,
    START      = 3'd1,
    RUN        = 3'd2,
    OVER_HELD  = 3'd3,
    OVER_ARMED = 3'd4,
    RESTART    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            game_rst_q, game_rst_d;
  logic            over_q, over_d;
  logic [15:0]     hi_q;
  logic            bgtype_q;
  logic [3:0]      bg_q;
  logic [PW-1:0]   presc_q;
  logic [15:0]     score_mod;
  logic            key_held;

  assign key_held  = (bus.key != 2'b00);
  assign score_mod = bus.score % PERIOD;

  // Next-state decode; the held-reset and game-over flags follow the next state
  // so their registered copies change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FROZEN:     if (key_held)    state_d = START;
      START:      if (!key_held)   state_d = RUN;
      RUN:        if (bus.collide) state_d = OVER_HELD;
      OVER_HELD:  if (!key_held)   state_d = OVER_ARMED;
      OVER_ARMED: if (key_held)    state_d = RESTART;
      RESTART:    if (!key_held)   state_d = RUN;
      default:                     state_d = FROZEN;
    endcase
    game_rst_d = (state_d == FROZEN) || (state_d == START) || (state_d == RESTART);
    over_d     = (state_d == OVER_HELD) || (state_d == OVER_ARMED);
  end

  // State register with registered flow flags and high-score capture on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FROZEN;
      game_rst_q <= 1'b1;
      over_q     <= 1'b0;
      hi_q       <= 16'h0000;
    end else begin
      state_q    <= state_d;
      game_rst_q <= game_rst_d;
      over_q     <= over_d;
      if ((state_q == RUN) && bus.collide && (bus.score > hi_q))
        hi_q <= bus.score;
    end
  end

  // Day/night target selection and prescaled brightness fade, active only
  // while running and not colliding; held in the game-over states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bgtype_q <= 1'b1;
      bg_q     <= 4'hF;
      presc_q  <= '0;
    end else if (game_rst_q) begin
      bgtype_q <= 1'b1;
      bg_q     <= 4'hF;
      presc_q  <= '0;
    end else if ((state_q == RUN) && !bus.collide) begin
      if ((score_mod == 16'h0000) && (bus.score != 16'h0000))
        bgtype_q <= 1'b0;
      else if (score_mod == DAY_START)
        bgtype_q <= 1'b1;

      if (bus.game_tick) begin
        if (presc_q == PRESC_LAST) begin
          presc_q <= '0;
          if (bgtype_q && (bg_q != 4'hF))
            bg_q <= bg_q + 4'd1;
          else if (!bgtype_q && (bg_q != 4'h0))
            bg_q <= bg_q - 4'd1;
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
    end
  end

  assign bus.game_rst = game_rst_q;
  assign bus.over     = over_q;
  assign bus.hi       = hi_q;
  assign bus.bgtype   = bgtype_q;
  assign bus.bg       = bg_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for the game-flow sequencer: start, collision/high score,
// restart handshake, night fade, day return, collision priority, async reset.
module tb_game_flow_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  game_flow_ctrl_if bus ();

  game_flow_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.game_tick = 1'b1;
      step();
      bus.game_tick = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.key       = 2'b00;
    bus.collide   = 1'b0;
    bus.game_tick = 1'b0;
    bus.score     = 16'h0000;
    #12;
    checks++;
    if (bus.game_rst !== 1'b1) begin errors++; $display("FAIL reset_game_rst got %b exp 1", bus.game_rst); end
    checks++;
    if (bus.over !== 1'b0) begin errors++; $display("FAIL reset_over got %b exp 0", bus.over); end
    checks++;
    if (bus.hi !== 16'h0000) begin errors++; $display("FAIL reset_hi got %h exp 0000", bus.hi); end
    checks++;
    if (bus.bg !== 4'hF || bus.bgtype !== 1'b1) begin errors++; $display("FAIL reset_bg got bg=%h bgtype=%b exp F/1", bus.bg, bus.bgtype); end
    checks++;
    if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_start();
    bus.key = 2'b01;
    step();
    checks++;
    if (bus.state !== 3'd1 || bus.game_rst !== 1'b1) begin errors++; $display("FAIL start_press got state=%0d game_rst=%b exp 1/1", bus.state, bus.game_rst); end
    bus.key = 2'b00;
    step();
    checks++;
    if (bus.state !== 3'd2 || bus.game_rst !== 1'b0) begin errors++; $display("FAIL start_release got state=%0d game_rst=%b exp 2/0", bus.state, bus.game_rst); end
    step();
    checks++;
    if (bus.bgtype !== 1'b1) begin errors++; $display("FAIL score_zero_no_night got bgtype=%b exp 1", bus.bgtype); end
  endtask

  task automatic test_collision();
    bus.score = 16'h0123;
    step();
    checks++;
    if (bus.bgtype !== 1'b1 || bus.over !== 1'b0) begin errors++; $display("FAIL run_hold got bgtype=%b over=%b exp 1/0", bus.bgtype, bus.over); end
    bus.collide = 1'b1;
    step();
    bus.collide = 1'b0;
    checks++;
    if (bus.over !== 1'b1 || bus.state !== 3'd3) begin errors++; $display("FAIL collide_over got over=%b state=%0d exp 1/3", bus.over, bus.state); end
    checks++;
    if (bus.hi !== 16'h0123) begin errors++; $display("FAIL collide_hi got %h exp 0123", bus.hi); end
  endtask

  task automatic test_restart();
    bus.key = 2'b01;
    step();
    checks++;
    if (bus.state !== 3'd3 || bus.over !== 1'b1) begin errors++; $display("FAIL over_held got state=%0d over=%b exp 3/1", bus.state, bus.over); end
    bus.key = 2'b00;
    step();
    checks++;
    if (bus.state !== 3'd4 || bus.over !== 1'b1) begin errors++; $display("FAIL over_armed got state=%0d over=%b exp 4/1", bus.state, bus.over); end
    bus.key = 2'b10;
    step();
    checks++;
    if (bus.over !== 1'b0 || bus.game_rst !== 1'b1 || bus.state !== 3'd5) begin errors++; $display("FAIL restart_press got over=%b game_rst=%b state=%0d exp 0/1/5", bus.over, bus.game_rst, bus.state); end
    bus.collide = 1'b1;
    step();
    checks++;
    if (bus.state !== 3'd5 || bus.over !== 1'b0) begin errors++; $display("FAIL restart_collide got state=%0d over=%b exp 5/0", bus.state, bus.over); end
    bus.collide = 1'b0;
    bus.key     = 2'b00;
    step();
    checks++;
    if (bus.state !== 3'd2 || bus.game_rst !== 1'b0) begin errors++; $display("FAIL restart_release got state=%0d game_rst=%b exp 2/0", bus.state, bus.game_rst); end
  endtask

  task automatic test_hi_hold();
    bus.score   = 16'h0100;
    bus.collide = 1'b1;
    step();
    bus.collide = 1'b0;
    checks++;
    if (bus.over !== 1'b1 || bus.hi !== 16'h0123) begin errors++; $display("FAIL hi_hold got over=%b hi=%h exp 1/0123", bus.over, bus.hi); end
    step();
    bus.key = 2'b01;
    step();
    bus.key = 2'b00;
    step();
    checks++;
    if (bus.state !== 3'd2) begin errors++; $display("FAIL rerun got state=%0d exp 2", bus.state); end
  endtask

  task automatic test_night_fade();
    bus.score = 16'h0700;
    step();
    checks++;
    if (bus.bgtype !== 1'b0 || bus.bg !== 4'hF) begin errors++; $display("FAIL night_type got bgtype=%b bg=%h exp 0/F", bus.bgtype, bus.bg); end
    ticks(31);
    checks++;
    if (bus.bg !== 4'hF) begin errors++; $display("FAIL fade_31 got %h exp F", bus.bg); end
    ticks(1);
    checks++;
    if (bus.bg !== 4'hE) begin errors++; $display("FAIL fade_32 got %h exp E", bus.bg); end
    ticks(32 * 14 - 1);
    checks++;
    if (bus.bg !== 4'h1) begin errors++; $display("FAIL fade_479 got %h exp 1", bus.bg); end
    ticks(1);
    checks++;
    if (bus.bg !== 4'h0) begin errors++; $display("FAIL fade_480 got %h exp 0", bus.bg); end
    ticks(32);
    checks++;
    if (bus.bg !== 4'h0) begin errors++; $display("FAIL fade_floor got %h exp 0", bus.bg); end
  endtask

  task automatic test_day_return();
    bus.score = 16'h0900;
    step();
    checks++;
    if (bus.bgtype !== 1'b1 || bus.bg !== 4'h0) begin errors++; $display("FAIL day_type got bgtype=%b bg=%h exp 1/0", bus.bgtype, bus.bg); end
    ticks(32);
    checks++;
    if (bus.bg !== 4'h1) begin errors++; $display("FAIL day_ramp got %h exp 1", bus.bg); end
    ticks(31);
    bus.game_tick = 1'b1;
    bus.collide   = 1'b1;
    bus.key       = 2'b01;
    step();
    bus.game_tick = 1'b0;
    bus.collide   = 1'b0;
    checks++;
    if (bus.bg !== 4'h1 || bus.over !== 1'b1) begin errors++; $display("FAIL collide_priority got bg=%h over=%b exp 1/1", bus.bg, bus.over); end
    checks++;
    if (bus.hi !== 16'h0900) begin errors++; $display("FAIL day_hi got %h exp 0900", bus.hi); end
    ticks(64);
    checks++;
    if (bus.bg !== 4'h1 || bus.state !== 3'd3) begin errors++; $display("FAIL over_freeze got bg=%h state=%0d exp 1/3", bus.bg, bus.state); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== 3'd0 || bus.game_rst !== 1'b1 || bus.over !== 1'b0) begin errors++; $display("FAIL async_flow got state=%0d game_rst=%b over=%b exp 0/1/0", bus.state, bus.game_rst, bus.over); end
    checks++;
    if (bus.hi !== 16'h0000 || bus.bg !== 4'hF || bus.bgtype !== 1'b1) begin errors++; $display("FAIL async_regs got hi=%h bg=%h bgtype=%b exp 0000/F/1", bus.hi, bus.bg, bus.bgtype); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_start();
    test_collision();
    test_restart();
    test_hi_hold();
    test_night_fade();
    test_day_return();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
